// File: rtl/step_sequencer.sv
// Assembles WORD_W-bit trace words into STEP_W-bit steps, queues them with a sequence index.
// Defining STEP_SEQ_PAD_CHECK_EN builds the zero-padding check on the last word of each step.
module step_sequencer #(
  parameter int STEP_W = 560,
  parameter int WORD_W = 64,
  parameter int DEPTH  = 2,
  parameter int IDX_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [STEP_W-1:0] out_step,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic              err_pad,
  output logic              err_trunc
);

  localparam int WORDS  = (STEP_W + WORD_W - 1) / WORD_W;
  localparam int PAD    = WORDS * WORD_W - STEP_W;
  localparam int LAST_W = WORD_W - PAD;
  localparam int CNT_W  = $clog2(WORDS);
  localparam int AIDX_W = $clog2(WORDS - 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FCNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  WCNT_LAST = CNT_W'(WORDS - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(DEPTH);

  typedef enum logic {S_FILL, S_CLOSED} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    wcnt_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [FCNT_W-1:0]   count_q;
  logic [IDX_W-1:0]    idx_q;
  logic                err_trunc_q;

  logic [WORD_W-1:0]   asm_q     [WORDS-1];
  logic [STEP_W-1:0]   mem_q     [DEPTH];
  logic [IDX_W-1:0]    idx_mem_q [DEPTH];

  logic                at_last;
  logic                accept;
  logic                push;
  logic                pop;
  logic [STEP_W-1:0]   step_d;

  assign at_last  = (wcnt_q == WCNT_LAST);
  assign in_ready = (state_q == S_FILL) && !(at_last && (count_q == FIFO_FULL));
  assign accept   = in_valid && in_ready;
  assign push     = accept && at_last;
  assign pop      = out_valid && out_ready;

  // The final word bypasses the assembly buffer and goes straight into the FIFO entry.
  generate
    for (genvar gi = 0; gi < WORDS - 1; gi++) begin : g_asm
      assign step_d[gi*WORD_W +: WORD_W] = asm_q[gi];
    end
  endgenerate
  assign step_d[STEP_W-1 -: LAST_W] = in_word[LAST_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FILL;
      wcnt_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      err_trunc_q <= 1'b0;
    end else begin
      if (accept) begin
        if (at_last) begin
          wcnt_q   <= '0;
          idx_q    <= idx_q + IDX_W'(1);
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
          if (in_last) state_q <= S_CLOSED;
        end else if (in_last) begin
          wcnt_q      <= '0;
          err_trunc_q <= 1'b1;
          state_q     <= S_CLOSED;
        end else begin
          wcnt_q <= wcnt_q + CNT_W'(1);
        end
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + FCNT_W'(1);
        2'b01:   count_q <= count_q - FCNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by wcnt_q and count_q.
  always_ff @(posedge clk) begin
    if (accept && !at_last) asm_q[wcnt_q[AIDX_W-1:0]] <= in_word;
    if (push) begin
      mem_q[wr_ptr_q]     <= step_d;
      idx_mem_q[wr_ptr_q] <= idx_q;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_step  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_idx   = out_valid ? idx_mem_q[rd_ptr_q] : '0;
  assign done      = (state_q == S_CLOSED) && (count_q == '0);
  assign err_trunc = err_trunc_q;

`ifdef STEP_SEQ_PAD_CHECK_EN
  logic err_pad_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pad_q <= 1'b0;
    end else if (push && (in_word[WORD_W-1 -: PAD] != '0)) begin
      err_pad_q <= 1'b1;
    end
  end
  assign err_pad = err_pad_q;
`else
  logic unused_pad;
  assign unused_pad = ^in_word[WORD_W-1 -: PAD];
  assign err_pad    = 1'b0;
`endif

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: scoreboard of expected steps, checked on every pop.
module tb_step_sequencer;
  localparam int STEP_W = 560;
  localparam int WORD_W = 64;
  localparam int DEPTH  = 2;
  localparam int IDX_W  = 32;
  localparam int WORDS  = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic [WORD_W-1:0] in_word;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [STEP_W-1:0] out_step;
  logic [IDX_W-1:0]  out_idx;
  logic              out_valid;
  logic              out_ready;
  logic              done;
  logic              err_pad;
  logic              err_trunc;

  step_sequencer #(.STEP_W(STEP_W), .WORD_W(WORD_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_step(out_step), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .done(done), .err_pad(err_pad), .err_trunc(err_trunc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [STEP_W-1:0] exp_step_q[$];
  logic [IDX_W-1:0]  exp_idx_q[$];
  logic [IDX_W-1:0]  next_idx;
  logic              exp_pad;

  task automatic check(input string tag, input logic [STEP_W-1:0] obs, input logic [STEP_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    check(tag, STEP_W'(obs), STEP_W'(exp));
  endtask

  function automatic logic [WORD_W-1:0] mk_word(input int s, input int k);
    logic [WORD_W-1:0] w;
    w = {32'hA5A5_0000 | 32'(k), 32'(k) ^ (32'(s) << 8)};
    if (k == WORDS - 1) w[63:48] = '0;
    return w;
  endfunction

  function automatic logic [STEP_W-1:0] mk_step(input int s, input logic ovr, input logic [WORD_W-1:0] w8);
    logic [WORDS*WORD_W-1:0] full;
    for (int k = 0; k < WORDS; k++) full[k*WORD_W +: WORD_W] = mk_word(s, k);
    if (ovr) full[(WORDS-1)*WORD_W +: WORD_W] = w8;
    return full[STEP_W-1:0];
  endfunction

  // Holds the word until accepted; returns #1 after the accepting edge.
  task automatic send_word(input logic [WORD_W-1:0] w, input logic last);
    int   waited = 0;
    logic ok = 1'b0;
    in_word  = w;
    in_valid = 1'b1;
    in_last  = last;
    while (!ok && waited < 100) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) chk1("accept_timeout", ok, 1'b1);
  endtask

  task automatic push_exp(input logic [STEP_W-1:0] s);
    exp_step_q.push_back(s);
    exp_idx_q.push_back(next_idx);
    next_idx = next_idx + 1;
  endtask

  task automatic send_step(input int s, input logic last, input logic ovr, input logic [WORD_W-1:0] w8);
    for (int k = 0; k < WORDS - 1; k++) send_word(mk_word(s, k), 1'b0);
    send_word(ovr ? w8 : mk_word(s, WORDS - 1), last);
    push_exp(mk_step(s, ovr, w8));
  endtask

  task automatic send_partial(input int s, input int n, input logic last_on_nth);
    for (int k = 0; k < n; k++) send_word(mk_word(s, k), last_on_nth && (k == n - 1));
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    exp_step_q.delete();
    exp_idx_q.delete();
    next_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (exp_idx_q.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    check(tag, STEP_W'(exp_idx_q.size()), STEP_W'(0));
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_idx_q.size() == 0) begin
        check("unexpected_pop", STEP_W'(exp_idx_q.size()), STEP_W'(1));
      end else begin
        logic [IDX_W-1:0]  e_idx;
        logic [STEP_W-1:0] e_step;
        e_idx  = exp_idx_q.pop_front();
        e_step = exp_step_q.pop_front();
        $display("pop idx=%0d step[63:0]=%h", out_idx, out_step[63:0]);
        check("out_idx", STEP_W'(out_idx), STEP_W'(e_idx));
        check("out_step", out_step, e_step);
      end
    end
  end

  initial begin
    logic [STEP_W-1:0] held_step;
    logic [IDX_W-1:0]  held_idx;
`ifdef STEP_SEQ_PAD_CHECK_EN
    exp_pad = 1'b1;
`else
    exp_pad = 1'b0;
`endif
    rst = 1'b1; in_word = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; next_idx = '0;
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    check("rst_out_step", out_step, '0);
    check("rst_out_idx", STEP_W'(out_idx), '0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err_pad", err_pad, 1'b0);
    chk1("rst_err_trunc", err_trunc, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: single step, latency and first word
    out_ready = 1'b1;
    for (int k = 0; k < WORDS - 1; k++) send_word(mk_word(0, k), 1'b0);
    chk1("t1_valid_before", out_valid, 1'b0);
    send_word(mk_word(0, WORDS - 1), 1'b0);
    chk1("t1_latency", out_valid, 1'b1);
    check("t1_idx", STEP_W'(out_idx), '0);
    check("t1_word0", STEP_W'(out_step[63:0]), STEP_W'(64'hA5A5_0000_0000_0000));
    push_exp(mk_step(0, 1'b0, '0));
    wait_drain("t1_drain");

    // 2: backpressure with a full FIFO
    apply_reset();
    send_step(1, 1'b0, 1'b0, '0);
    send_step(2, 1'b0, 1'b0, '0);
    send_partial(3, WORDS - 1, 1'b0);
    @(negedge clk);
    chk1("t2_in_ready_full", in_ready, 1'b0);
    check("t2_head_idx", STEP_W'(out_idx), '0);
    held_step = out_step;
    held_idx  = out_idx;
    @(negedge clk);
    check("t2_stable_step", out_step, held_step);
    check("t2_stable_idx", STEP_W'(out_idx), STEP_W'(held_idx));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_word(mk_word(3, WORDS - 1), 1'b0);
    push_exp(mk_step(3, 1'b0, '0));
    wait_drain("t2_drain");

    // 3: truncated final step
    apply_reset();
    send_step(4, 1'b0, 1'b0, '0);
    send_partial(5, 5, 1'b1);
    chk1("t3_err_trunc", err_trunc, 1'b1);
    chk1("t3_in_ready", in_ready, 1'b0);
    chk1("t3_done_early", done, 1'b0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("t3_drain");
    repeat (3) @(posedge clk);
    #1;
    chk1("t3_no_extra", out_valid, 1'b0);
    chk1("t3_done", done, 1'b1);
    chk1("t3_trunc_sticky", err_trunc, 1'b1);
    chk1("t3_in_ready_closed", in_ready, 1'b0);

    // 4: padding check
    apply_reset();
    out_ready = 1'b1;
    send_step(6, 1'b0, 1'b0, '0);
    chk1("t4_pad_clean", err_pad, 1'b0);
    send_step(7, 1'b0, 1'b1, 64'h0001_0000_0000_0000);
    chk1("t4_err_pad", err_pad, exp_pad);
    wait_drain("t4_drain");
    chk1("t4_pad_sticky", err_pad, exp_pad);

    // 5: asynchronous reset mid-step
    apply_reset();
    out_ready = 1'b1;
    send_step(8, 1'b0, 1'b0, '0);
    wait_drain("t5_drain_a");
    out_ready = 1'b0;
    send_step(9, 1'b0, 1'b0, '0);
    send_partial(10, 6, 1'b0);
    chk1("t5_valid_pre", out_valid, 1'b1);
    #2;
    rst = 1'b1;
    exp_step_q.delete();
    exp_idx_q.delete();
    next_idx = '0;
    #1;
    chk1("t5_async_valid", out_valid, 1'b0);
    chk1("t5_async_ready", in_ready, 1'b1);
    check("t5_async_idx", STEP_W'(out_idx), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send_step(11, 1'b0, 1'b0, '0);
    wait_drain("t5_drain_b");

    // 6: back-to-back steps closed by in_last
    apply_reset();
    out_ready = 1'b1;
    for (int s = 0; s < 4; s++) send_step(12 + s, s == 3, 1'b0, '0);
    chk1("t6_done_early", done, 1'b0);
    chk1("t6_in_ready", in_ready, 1'b0);
    wait_drain("t6_drain");
    chk1("t6_done", done, 1'b1);
    chk1("t6_in_ready_closed", in_ready, 1'b0);
    chk1("t6_no_trunc", err_trunc, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
